handshake_receiver: RTL and testbench

HANDSHAKE_RECEIVER -- requirements
Module: handshake_receiver

---
 rtl/handshake_receiver_pkg.sv | 13 +
 rtl/handshake_receiver_fifo.sv | 63 ++++++
 rtl/handshake_receiver.sv | 132 +++++++++++++
 tb/tb_handshake_receiver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/handshake_receiver_pkg.sv
// Shared definitions for the handshake receiver: checker state encoding and
// the width of the statistics counters.
package handshake_receiver_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } chk_state_t;

endpackage : handshake_receiver_pkg

// File: rtl/handshake_receiver_fifo.sv
// Small synchronous FIFO used as the receive buffer; storage is not reset,
// only pointers and occupancy are.
module hs_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;

    logic w_doPush;
    logic w_doPop;

    assign full     = (r_count == CNT_FULL);
    assign empty    = (r_count == '0);
    assign w_doPush = push && !full;
    assign w_doPop  = pop && !empty;
    assign rdata    = r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            // Simultaneous push and pop leave occupancy unchanged.
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : hs_sync_fifo

// File: rtl/handshake_receiver.sv
// Valid/ready receiver: buffers words in a FIFO, drains them when the consumer
// allows, and checks that accepted words form an incrementing sequence.
module handshake_receiver
    import handshake_receiver_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [DW-1:0]    data_i,
    output logic             ready_o,
    input  logic             random_stall,
    input  logic             clr_i,
    output logic             rx_vld_o,
    output logic [DW-1:0]    rx_data_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] rx_cnt_o
);

    localparam logic [DW-1:0]    DATA_ONE = 1;
    localparam logic [CNT_W-1:0] STAT_ONE = 1;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [DW-1:0] w_rdata;

    chk_state_t    r_state;
    chk_state_t    w_nextState;
    logic [DW-1:0] r_expected;
    logic [DW-1:0] w_nextExpected;
    logic          w_mismatch;

    logic             r_rxVld;
    logic [DW-1:0]    r_rxData;
    logic             r_err;
    logic [CNT_W-1:0] r_errCnt;
    logic [CNT_W-1:0] r_rxCnt;

    // ready_o depends only on registered occupancy, never on valid_i.
    assign ready_o = !w_full;
    assign w_push  = valid_i && ready_o;
    assign w_pop   = random_stall && !w_empty;

    hs_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (data_i),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxVld  <= 1'b0;
            r_rxData <= '0;
        end else begin
            r_rxVld <= w_pop;
            if (w_pop) begin
                r_rxData <= w_rdata;
            end
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_nextExpected = r_expected;
        w_mismatch     = 1'b0;
        if (w_push) begin
            case (r_state)
                SYNC: begin
                    w_nextState    = RUN;
                    w_nextExpected = data_i + DATA_ONE;
                end
                RUN: begin
                    if (data_i == r_expected) begin
                        w_nextExpected = r_expected + DATA_ONE;
                    end else begin
                        w_mismatch     = 1'b1;
                        w_nextExpected = data_i + DATA_ONE;
                    end
                end
                default: w_nextState = SYNC;
            endcase
        end
    end

    // Clear wins over a push in the same cycle; that word is neither checked nor counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= SYNC;
            r_expected <= '0;
            r_err      <= 1'b0;
            r_errCnt   <= '0;
            r_rxCnt    <= '0;
        end else if (clr_i) begin
            r_state  <= SYNC;
            r_err    <= 1'b0;
            r_errCnt <= '0;
            r_rxCnt  <= '0;
        end else begin
            r_state    <= w_nextState;
            r_expected <= w_nextExpected;
            if (w_push) begin
                r_rxCnt <= r_rxCnt + STAT_ONE;
            end
            if (w_mismatch) begin
                r_err <= 1'b1;
                if (r_errCnt != CNT_MAX) begin
                    r_errCnt <= r_errCnt + STAT_ONE;
                end
            end
        end
    end

    assign rx_vld_o  = r_rxVld;
    assign rx_data_o = r_rxData;
    assign err_o     = r_err;
    assign err_cnt_o = r_errCnt;
    assign rx_cnt_o  = r_rxCnt;

endmodule : handshake_receiver

// File: tb/tb_handshake_receiver.sv
// Directed testbench for handshake_receiver: streaming, backpressure,
// sequence errors, wrap, clear, reset and error counter saturation.
module tb_handshake_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic        ready_o;
    logic        random_stall = 1'b0;
    logic        clr_i = 1'b0;
    logic        rx_vld_o;
    logic [7:0]  rx_data_o;
    logic        err_o;
    logic [15:0] err_cnt_o;
    logic [15:0] rx_cnt_o;

    int checkCount = 0;
    int passCount  = 0;
    logic [7:0] rxQ[$];

    handshake_receiver #(.DW(8), .DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .random_stall (random_stall),
        .clr_i        (clr_i),
        .rx_vld_o     (rx_vld_o),
        .rx_data_o    (rx_data_o),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o),
        .rx_cnt_o     (rx_cnt_o)
    );

    always #5 clk = ~clk;

    // Every delivered word is captured mid-cycle so ordering can be checked later.
    always @(negedge clk) begin
        if (rx_vld_o === 1'b1) begin
            rxQ.push_back(rx_data_o);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then let the edge happen and settle 1ns after it.
    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic s, input logic c);
        valid_i      = v;
        data_i       = d;
        random_stall = s;
        clr_i        = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic s);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, s, 1'b0);
        end
    endtask

    task automatic pushWord(input logic [7:0] d);
        applyStimulus(1'b1, d, 1'b1, 1'b0);
    endtask

    initial begin
        int idx;
        logic acc;

        // Reset state
        rst_n = 1'b0;
        idleCycles(2, 1'b0);
        rst_n = 1'b1;
        checkOutput("rst_ready", ready_o, 1);
        checkOutput("rst_rx_vld", rx_vld_o, 0);
        checkOutput("rst_rx_data", rx_data_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_err_cnt", err_cnt_o, 0);
        checkOutput("rst_rx_cnt", rx_cnt_o, 0);

        // Continuous stream 0..9 with the consumer always draining
        rxQ.delete();
        for (int i = 0; i < 10; i++) begin
            pushWord(8'(i));
            if (i == 0) checkOutput("lat_not_yet", rx_vld_o, 0);
            if (i == 1) begin
                checkOutput("lat_vld_2cyc", rx_vld_o, 1);
                checkOutput("lat_data_2cyc", rx_data_o, 0);
            end
        end
        idleCycles(4, 1'b1);
        checkOutput("stream_count", rxQ.size(), 10);
        for (int i = 0; i < 10 && i < rxQ.size(); i++) begin
            checkOutput($sformatf("stream_word%0d", i), rxQ[i], i);
        end
        checkOutput("stream_err", err_o, 0);
        checkOutput("stream_rx_cnt", rx_cnt_o, 10);

        // Backpressure: 10..15 continue the sequence, consumer stalled first
        rxQ.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(10 + i), 1'b0, 1'b0);
        end
        checkOutput("bp_ready_full", ready_o, 0);
        idleCycles(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'd14, 1'b0, 1'b0);
        end
        checkOutput("bp_rx_cnt_held", rx_cnt_o, 14);
        checkOutput("bp_no_output", rxQ.size(), 0);
        idx = 4;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            acc = ready_o;
            applyStimulus(1'b1, 8'(10 + idx), 1'b1, 1'b0);
            if (acc) idx++;
        end
        checkOutput("bp_accept_all", idx, 6);
        idleCycles(8, 1'b1);
        checkOutput("bp_count", rxQ.size(), 6);
        for (int i = 0; i < 6 && i < rxQ.size(); i++) begin
            checkOutput($sformatf("bp_word%0d", i), rxQ[i], 10 + i);
        end
        checkOutput("bp_err", err_o, 0);
        checkOutput("bp_rx_cnt", rx_cnt_o, 16);

        // Sequence error: 5,6,8,9 -> single mismatch on 8, resync makes 9 a match
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        pushWord(8'd5);
        pushWord(8'd6);
        checkOutput("seq_no_err_yet", err_o, 0);
        pushWord(8'd8);
        checkOutput("seq_err_on_8", err_o, 1);
        checkOutput("seq_cnt_on_8", err_cnt_o, 1);
        pushWord(8'd9);
        checkOutput("seq_9_match", err_cnt_o, 1);
        checkOutput("seq_rx_cnt", rx_cnt_o, 4);
        idleCycles(4, 1'b1);

        // Clear with a simultaneous push of 20
        rxQ.delete();
        applyStimulus(1'b1, 8'd20, 1'b1, 1'b1);
        checkOutput("clr_err", err_o, 0);
        checkOutput("clr_err_cnt", err_cnt_o, 0);
        checkOutput("clr_rx_cnt", rx_cnt_o, 0);
        idleCycles(3, 1'b1);
        checkOutput("clr_delivered_n", rxQ.size(), 1);
        if (rxQ.size() > 0) checkOutput("clr_delivered_20", rxQ[0], 20);
        pushWord(8'd40);
        pushWord(8'd41);
        checkOutput("clr_resync_err", err_o, 0);
        checkOutput("clr_resync_cnt", rx_cnt_o, 2);

        // Wrap: 254,255,0,1 is a valid sequence
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        pushWord(8'd254);
        pushWord(8'd255);
        pushWord(8'd0);
        pushWord(8'd1);
        checkOutput("wrap_err", err_o, 0);
        checkOutput("wrap_err_cnt", err_cnt_o, 0);
        checkOutput("wrap_rx_cnt", rx_cnt_o, 4);
        idleCycles(4, 1'b1);

        // Reset with three words buffered: nothing may come out afterwards
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(1 + i), 1'b0, 1'b0);
        end
        rxQ.delete();
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        rst_n = 1'b1;
        idleCycles(6, 1'b1);
        checkOutput("rst_mid_no_vld", rxQ.size(), 0);
        checkOutput("rst_mid_ready", ready_o, 1);
        checkOutput("rst_mid_rx_cnt", rx_cnt_o, 0);

        // Saturation: a run of zeros mismatches on every word after the first
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 65538; i++) begin
            pushWord(8'd0);
        end
        checkOutput("sat_err_cnt", err_cnt_o, 32'h0000_FFFF);
        checkOutput("sat_err", err_o, 1);
        checkOutput("sat_rx_cnt_wrap", rx_cnt_o, 2);
        pushWord(8'd0);
        checkOutput("sat_err_cnt_hold", err_cnt_o, 32'h0000_FFFF);
        idleCycles(4, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_handshake_receiver
